// File: rtl/byte_sub_shift_row_if.sv
// ---------------------------------------------------------------------------
// byte_sub_shift_row_if
// Groups the ap_* block handshake and the dual-port statemt memory bus used
// by the AES SubBytes/ShiftRows stage.
//   ap_start             controller -> stage  start request
//   ap_done/ap_ready     stage -> controller  one-cycle completion pulses
//   ap_idle              stage -> controller  high while waiting for a start
//   statemt_*0 / *1      two memory ports: address, ce, we, write data out;
//                        read data (q) back into the stage one cycle later
// slave  : the stage itself
// master : the controller/memory side that drives start and read data
// ---------------------------------------------------------------------------
interface byte_sub_shift_row_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [ADDR_W-1:0] statemt_address0;
    logic              statemt_ce0;
    logic              statemt_we0;
    logic [DATA_W-1:0] statemt_d0;
    logic [DATA_W-1:0] statemt_q0;
    logic [ADDR_W-1:0] statemt_address1;
    logic              statemt_ce1;
    logic              statemt_we1;
    logic [DATA_W-1:0] statemt_d1;
    logic [DATA_W-1:0] statemt_q1;

    modport slave (
        input  ap_start, statemt_q0, statemt_q1,
        output ap_done, ap_idle, ap_ready,
        output statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
        output statemt_address1, statemt_ce1, statemt_we1, statemt_d1
    );

    modport master (
        output ap_start, statemt_q0, statemt_q1,
        input  ap_done, ap_idle, ap_ready,
        input  statemt_address0, statemt_ce0, statemt_we0, statemt_d0,
        input  statemt_address1, statemt_ce1, statemt_we1, statemt_d1
    );
endinterface

// File: rtl/byte_sub_shift_row.sv
// ---------------------------------------------------------------------------
// byte_sub_shift_row
// AES round stage: reads the 16-byte state (statemt words 0..15, column
// major, byte (r,c) at word r+4c), applies SubBytes and ShiftRows, and writes
// the result back in place, zero-extended to the full word.
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset, forces IDLE
//   bus       byte_sub_shift_row_if.slave: ap_* handshake + two memory ports
// Timing: accept in cycle 0, reads in 1-8, last capture in 9, writes in
// 10-17, ap_done/ap_ready in 18, idle again in 19.
// ---------------------------------------------------------------------------
module byte_sub_shift_row #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic                  ap_clk,
    input logic                  ap_rst_n,
    byte_sub_shift_row_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RLAST = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] SBOX_LUT [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Forward AES S-box lookup.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_LUT[x];
    endfunction

    // ShiftRows source for output word o = {col, row}: row r is rotated left
    // by r, so it comes from column (col + row) mod 4 of the same row.
    // The 2-bit sum wraps, which is exactly the mod 4.
    function automatic logic [3:0] src_index(input logic [3:0] o);
        logic [1:0] col_s;
        col_s = o[3:2] + o[1:0];
        return {col_s, o[1:0]};
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        k_prev_s;
    logic [7:0]        buf_q [16];
    logic [7:0]        buf_d [16];
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [DATA_W-1:0] wdata0_q, wdata0_d;
    logic [DATA_W-1:0] wdata1_q, wdata1_d;
    logic              unused_upper_s;

    // Only the low byte of each state word carries data.
    assign unused_upper_s = ^{bus.statemt_q0[DATA_W-1:8], bus.statemt_q1[DATA_W-1:8]};

    // Next-state, buffer capture, and next value of every registered output.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        buf_d    = buf_q;
        ce_d     = 1'b0;
        we_d     = 1'b0;
        addr0_d  = '0;
        addr1_d  = '0;
        wdata0_d = '0;
        wdata1_d = '0;
        k_prev_s = k_q - 3'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    state_d = S_READ;
                    k_d     = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Read data lags the request by one cycle, so step k stores
                // the pair requested at step k-1.
                if (k_q != 3'd0) begin
                    buf_d[{k_prev_s, 1'b0}] = bus.statemt_q0[7:0];
                    buf_d[{k_prev_s, 1'b1}] = bus.statemt_q1[7:0];
                end else begin
                    buf_d = buf_q;
                end
                if (k_q == 3'd7) begin
                    state_d = S_RLAST;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_RLAST: begin
                buf_d[14] = bus.statemt_q0[7:0];
                buf_d[15] = bus.statemt_q1[7:0];
                state_d   = S_WRITE;
                k_d       = 3'd0;
            end
            S_WRITE: begin
                if (k_q == 3'd7) begin
                    state_d = S_DONE;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 3'd0;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        if ((state_d == S_READ) || (state_d == S_WRITE)) begin
            ce_d    = 1'b1;
            addr0_d = ADDR_W'({k_d, 1'b0});
            addr1_d = ADDR_W'({k_d, 1'b1});
        end else begin
            ce_d = 1'b0;
        end

        // buf_d (not buf_q) so the bytes captured in RLAST are already visible.
        if (state_d == S_WRITE) begin
            we_d     = 1'b1;
            wdata0_d = DATA_W'(sbox(buf_d[src_index({k_d, 1'b0})]));
            wdata1_d = DATA_W'(sbox(buf_d[src_index({k_d, 1'b1})]));
        end else begin
            we_d = 1'b0;
        end
    end

    // State, step counter and registered memory-port outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= 3'd0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            wdata0_q <= wdata0_d;
            wdata1_q <= wdata1_d;
        end
    end

    // State byte buffer; its content is irrelevant until a run refills it.
    always_ff @(posedge ap_clk) begin
        buf_q <= buf_d;
    end

    assign bus.ap_idle          = (state_q == S_IDLE);
    assign bus.ap_done          = (state_q == S_DONE);
    assign bus.ap_ready         = (state_q == S_DONE);
    assign bus.statemt_ce0      = ce_q;
    assign bus.statemt_ce1      = ce_q;
    assign bus.statemt_we0      = we_q;
    assign bus.statemt_we1      = we_q;
    assign bus.statemt_address0 = addr0_q;
    assign bus.statemt_address1 = addr1_q;
    assign bus.statemt_d0       = wdata0_q;
    assign bus.statemt_d1       = wdata1_q;

endmodule

// File: doc/byte_sub_shift_row.md
Name: byte_sub_shift_row

Overview:
- AES encryption round stage that sits directly upstream of the MixColumn/AddRoundKey stage. It operates in place on the same `statemt` memory (32 words of 32 bits; words 0..15 hold the 4x4 state).
- On `ap_start` it reads the 16 state bytes, applies the AES S-box (SubBytes) and ShiftRows, and writes the results back.
- It uses the same `ap_*` block-level handshake and dual-port memory interface as its downstream neighbour, so the controller can sequence the two back to back.

Parameters:
- ADDR_W, 5, `statemt` address width (32-word memory).
- DATA_W, 32, `statemt` word width; only bits [7:0] carry state data.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start request, sampled only in IDLE.
- ap_done  out  1  one-cycle pulse: results written.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- statemt_address0  out  ADDR_W  port 0 address.
- statemt_ce0  out  1  port 0 enable.
- statemt_we0  out  1  port 0 write enable.
- statemt_d0  out  DATA_W  port 0 write data.
- statemt_q0  in  DATA_W  port 0 read data, valid one cycle after the ce0 read.
- statemt_address1, statemt_ce1, statemt_we1, statemt_d1, statemt_q1: same as port 0, for port 1.

Behaviour:
- **State layout:** column-major. Byte (row r, col c) is at `statemt[r + 4*c]`, with r,c in 0..3.
- **Transform:** `out[r + 4*c] = SBOX(in[r + 4*((c + r) mod 4)][7:0])`.
  - The written word is zero-extended, so bits [31:8] are always 0.
  - Input bits [31:8] are ignored.
- **S-box:** the standard FIPS-197 forward S-box, implemented as a combinational 256-entry function.
- **Internal storage:** 16 x 8-bit buffer.
- **FSM states:** IDLE, READ, RLAST, WRITE, DONE.
- **IDLE:**
  - ap_idle=1; all ce/we = 0.
  - If ap_start=1, go to READ with k=0.
- **READ (8 cycles, k=0..7):**
  - ce0=ce1=1, we0=we1=0, address0=2k, address1=2k+1.
  - From k>=1, capture q0/q1 of the previous k into buf[2(k-1)] and buf[2(k-1)+1].
  - After k=7, go to RLAST.
- **RLAST (1 cycle):**
  - Capture buf[14] and buf[15]; no memory access.
  - Go to WRITE with k=0.
- **WRITE (8 cycles, k=0..7):**
  - ce0=ce1=1, we0=we1=1, address0=2k, address1=2k+1.
  - d0 = out[2k], d1 = out[2k+1], computed from buf.
  - After k=7, go to DONE.
- **DONE (1 cycle):** ap_done=ap_ready=1, then go to IDLE.
- **Latency:** accept in cycle 0; READ cycles 1-8; RLAST cycle 9; WRITE cycles 10-17; ap_done in cycle 18.
  - ap_idle returns high in cycle 19.
  - If ap_start is still high in cycle 19, a new run starts, giving a 19-cycle issue interval.
- **Start handling:** ap_start is ignored outside IDLE. Raising it mid-run has no effect.
- **Address range:** addresses 16..31 are never driven. Ports never address the same word in the same cycle.
- **Reset:** asserted at any time, including mid-READ or mid-WRITE, it forces IDLE immediately.
  - Outputs go to ap_done=0, ap_ready=0, ap_idle=1 (held high throughout reset), all ce/we=0, addresses=0, d=0.
  - Buffer contents are don't-care.
  - A partially written state stays partially written; the controller must restart the run.
- ce/we/address/d are registered outputs. No combinational path exists from any input to any output.

Test Plan:
- **FIPS-197 Appendix B round 1:** load `statemt[0..15]` = 19,3d,e3,be,a0,f4,e2,2b,9a,c6,8d,2a,e9,f8,48,08 and pulse ap_start -> `statemt[0..15]` = d4,bf,5d,30,e0,b4,52,ae,b8,41,11,f1,1e,27,98,e5; ap_done exactly 18 cycles after the start cycle.
- **All zeros and upper bits:** all words 0x00000000 -> every word 0x00000063. Word0 = 0xFFFFFF00 -> word0 = 0x00000063, confirming upper bits are dropped and zero-written.
- **Protocol check:** monitor every cycle -> ap_idle low from cycle 1 to 18; ce asserted only in cycles 1-8 and 10-17; we only in 10-17; no address ever >15; words 16..31 remain unchanged (prefilled 0xDEADBEEF).
- **Back-to-back runs:** hold ap_start high across two runs -> the second READ begins in cycle 20; the final state equals the transform applied twice (for Appendix B input, word0 = SBOX(0xd4) = 0x48).
- **Mid-operation reset:** assert ap_rst_n=0 in cycle 12 (mid-WRITE) -> ce/we drop asynchronously, ap_idle=1, no ap_done. After release, a fresh start with reloaded input yields the correct Appendix B result.
- **Start outside IDLE:** pulse ap_start in cycle 5 -> no effect; exactly one ap_done pulse is seen, in cycle 18.
